// File: rtl/half_subtractor_if.sv
// Signal bundle for the half subtractor: operands and control in, combinational
// and registered results out.
interface half_subtractor_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             cnt_clr;
    logic [WIDTH-1:0] difference;
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] difference_q;
    logic [WIDTH-1:0] borrow_q;
    logic             out_valid;
    logic [CNT_W-1:0] borrow_count;

    modport master (
        output a, b, in_valid, cnt_clr,
        input  difference, borrow, difference_q, borrow_q, out_valid, borrow_count
    );

    modport slave (
        input  a, b, in_valid, cnt_clr,
        output difference, borrow, difference_q, borrow_q, out_valid, borrow_count
    );
endinterface

// File: rtl/half_subtractor.sv
// Per-lane half subtractor with a combinational result, a one-cycle registered
// copy qualified by out_valid, and a saturating count of samples that borrowed.
module half_subtractor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    half_subtractor_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] difference_p0;
    logic [WIDTH-1:0] borrow_p0;
    logic             vld_p0;
    logic [WIDTH-1:0] difference_p1;
    logic [WIDTH-1:0] borrow_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] count_p1;

    // Stage p0: combinational result, independent of clk/rst/in_valid
    always_comb begin
        difference_p0 = bus.a ^ bus.b;
        borrow_p0     = ~bus.a & bus.b;
        vld_p0        = bus.in_valid;
    end

    assign bus.difference = difference_p0;
    assign bus.borrow     = borrow_p0;

    // Stage p1: registered copy; q outputs hold when no sample is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            difference_p1 <= '0;
            borrow_p1     <= '0;
            vld_p1        <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                difference_p1 <= difference_p0;
                borrow_p1     <= borrow_p0;
            end
        end
    end

    // Clear wins over a simultaneous borrow increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_p1 <= '0;
        end else if (bus.cnt_clr) begin
            count_p1 <= '0;
        end else if (vld_p0 && (|borrow_p0)) begin
            count_p1 <= sat_inc(count_p1);
        end
    end

    assign bus.difference_q = difference_p1;
    assign bus.borrow_q     = borrow_p1;
    assign bus.out_valid    = vld_p1;
    assign bus.borrow_count = count_p1;

endmodule

// File: tb/tb_half_subtractor.sv
// Directed plus randomized bench for two half_subtractor instances (1-lane with
// a 2-bit counter, 4-lane with an 8-bit counter) against an arithmetic model.
module tb_half_subtractor;

    logic clk;
    logic rst;
    logic clk_en;
    int   vectors;
    int   miscompares;

    half_subtractor_if #(.WIDTH(1), .CNT_W(2)) hs1 ();
    half_subtractor_if #(.WIDTH(4), .CNT_W(8)) hs4 ();

    half_subtractor #(.WIDTH(1), .CNT_W(2)) u_hs1 (.clk(clk), .rst(rst), .bus(hs1.slave));
    half_subtractor #(.WIDTH(4), .CNT_W(8)) u_hs4 (.clk(clk), .rst(rst), .bus(hs4.slave));

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    // Model state for each instance
    int m1_dq, m1_bq, m1_ov, m1_cnt;
    int m4_dq, m4_bq, m4_ov, m4_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane-by-lane subtraction a-b with integer arithmetic; a negative result borrows 2
    task automatic sub_model(input int w, input int av, input int bv,
                             output int d, output int br);
        d = 0;
        br = 0;
        for (int i = 0; i < w; i++) begin
            int x;
            x = ((av >> i) & 1) - ((bv >> i) & 1);
            if (x < 0) begin
                br += (1 << i);
                x += 2;
            end
            d += (x << i);
        end
    endtask

    task automatic cnt_model(input int cnt, input int cmax, input int v, input int clr,
                             input int br, output int nxt);
        if (clr != 0)                nxt = 0;
        else if (v != 0 && br != 0)  nxt = (cnt + 1 > cmax) ? cmax : cnt + 1;
        else                         nxt = cnt;
    endtask

    task automatic check_comb(input string tag);
        int d, br;
        sub_model(1, int'(hs1.a), int'(hs1.b), d, br);
        chk({tag, ".d1"}, 32'(hs1.difference), d);
        chk({tag, ".b1"}, 32'(hs1.borrow), br);
        sub_model(4, int'(hs4.a), int'(hs4.b), d, br);
        chk({tag, ".d4"}, 32'(hs4.difference), d);
        chk({tag, ".b4"}, 32'(hs4.borrow), br);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".dq1"}, 32'(hs1.difference_q), m1_dq);
        chk({tag, ".bq1"}, 32'(hs1.borrow_q), m1_bq);
        chk({tag, ".ov1"}, 32'(hs1.out_valid), m1_ov);
        chk({tag, ".cnt1"}, 32'(hs1.borrow_count), m1_cnt);
        chk({tag, ".dq4"}, 32'(hs4.difference_q), m4_dq);
        chk({tag, ".bq4"}, 32'(hs4.borrow_q), m4_bq);
        chk({tag, ".ov4"}, 32'(hs4.out_valid), m4_ov);
        chk({tag, ".cnt4"}, 32'(hs4.borrow_count), m4_cnt);
    endtask

    task automatic model_reset();
        m1_dq = 0; m1_bq = 0; m1_ov = 0; m1_cnt = 0;
        m4_dq = 0; m4_bq = 0; m4_ov = 0; m4_cnt = 0;
    endtask

    // One clock cycle: drive at negedge, check comb, advance model, check after posedge
    task automatic step(input string tag,
                        input int a1, input int b1, input int v1, input int c1,
                        input int a4, input int b4, input int v4, input int c4);
        int d, br, nxt;
        @(negedge clk);
        hs1.a = 1'(a1); hs1.b = 1'(b1); hs1.in_valid = 1'(v1); hs1.cnt_clr = 1'(c1);
        hs4.a = 4'(a4); hs4.b = 4'(b4); hs4.in_valid = 1'(v4); hs4.cnt_clr = 1'(c4);
        #1;
        check_comb(tag);
        sub_model(1, a1 & 1, b1 & 1, d, br);
        cnt_model(m1_cnt, 3, v1, c1, br, nxt);
        m1_cnt = nxt;
        m1_ov  = v1;
        if (v1 != 0) begin m1_dq = d; m1_bq = br; end
        sub_model(4, a4 & 15, b4 & 15, d, br);
        cnt_model(m4_cnt, 255, v4, c4, br, nxt);
        m4_cnt = nxt;
        m4_ov  = v4;
        if (v4 != 0) begin m4_dq = d; m4_bq = br; end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clk_en = 1'b0;
        rst = 1'b1;
        hs1.a = '0; hs1.b = '0; hs1.in_valid = 1'b0; hs1.cnt_clr = 1'b0;
        hs4.a = '0; hs4.b = '0; hs4.in_valid = 1'b0; hs4.cnt_clr = 1'b0;
        model_reset();
        #1;
        check_regs("reset");

        // Combinational truth table with the clock idle and reset held
        for (int i = 0; i < 4; i++) begin
            hs1.a = 1'(i >> 1);
            hs1.b = 1'(i & 1);
            hs4.a = 4'(i * 5);
            hs4.b = 4'(i * 3);
            #10;
            check_comb("sweep");
        end
        #1;
        check_regs("sweep_hold");

        rst = 1'b0;
        #4;
        clk_en = 1'b1;

        // Registered path: accept a=0,b=1, then drop in_valid and expect a hold
        step("reg_acc", 0, 1, 1, 0, 0, 0, 0, 0);
        chk("reg_acc.dq", 32'(hs1.difference_q), 1);
        chk("reg_acc.bq", 32'(hs1.borrow_q), 1);
        chk("reg_acc.ov", 32'(hs1.out_valid), 1);
        step("reg_hold", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("reg_hold.ov", 32'(hs1.out_valid), 0);
        chk("reg_hold.dq", 32'(hs1.difference_q), 1);

        // Saturation of the 2-bit counter, then clear beats a borrow sample
        step("clr", 0, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step("sat", 0, 1, 1, 0, 0, 0, 0, 0);
            chk("sat.seq", 32'(hs1.borrow_count), (i < 3) ? i + 1 : 3);
        end
        step("clr_pri", 0, 1, 1, 1, 0, 0, 0, 0);
        chk("clr_pri.cnt", 32'(hs1.borrow_count), 0);

        // Four-lane example: one accepted sample adds exactly one
        step("w4", 0, 0, 0, 0, 5, 3, 1, 0);
        chk("w4.dq", 32'(hs4.difference_q), 6);
        chk("w4.bq", 32'(hs4.borrow_q), 2);
        chk("w4.cnt", 32'(hs4.borrow_count), 1);

        // Async reset between edges with count=2 and out_valid=1
        step("pre_rst", 0, 1, 1, 1, 0, 0, 0, 0);
        step("pre_rst", 0, 1, 1, 0, 0, 0, 0, 0);
        step("pre_rst", 0, 1, 1, 0, 0, 0, 0, 0);
        chk("pre_rst.cnt", 32'(hs1.borrow_count), 2);
        chk("pre_rst.ov", 32'(hs1.out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("async_rst");
        hs1.a = 1'b1; hs1.b = 1'b0;
        hs4.a = 4'b0010; hs4.b = 4'b1001;
        #1;
        check_comb("rst_comb");
        @(negedge clk);
        rst = 1'b0;

        // Randomized back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            step("rand",
                 int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                 int'($urandom_range(3, 0) != 0), int'($urandom_range(15, 0) == 0),
                 int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                 int'($urandom_range(3, 0) != 0), int'($urandom_range(15, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
